// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline.
//   DW          - datapath width
//   MUL_CYCLES  - iterations of the sequential multiplier (one per operand bit)
//   ALU_*       - alu_cmd encodings
//   FWD_*       - forwarding select encodings for the operand muxes
//   mul_state_t - sequential multiplier FSM states
package pipe_pkg;

  localparam int DW         = 16;
  localparam int MUL_CYCLES = DW;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_MUL = 3'd7;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_mul16.sv
// Iterative shift-add multiplier, one partial-product step per clock.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - begin a multiply (honoured only in MUL_IDLE)
//   ack          - consumer took the product; leave MUL_DONE
//   op_a, op_b   - operands, sampled on the start edge
//   busy         - iterating (MUL_RUN)
//   done         - product valid and held (MUL_DONE)
//   product      - low DW bits of op_a * op_b
//   state        - FSM state, for debug/observation
// Handshake: start is a one-cycle request taken in IDLE; the product stays
// valid while done is high and is released on the first edge with ack = 1.
module seq_mul16
  import pipe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ack,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] product,
  output mul_state_t    state
);

  logic [4:0]    count;
  logic [DW-1:0] acc;
  logic [DW-1:0] mcand;   // shifts left each step
  logic [DW-1:0] mplier;  // shifts right each step; bit 0 gates the add

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MUL_IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
            state  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (count == 5'(MUL_CYCLES - 1)) state <= MUL_DONE;
        end
        MUL_DONE: begin
          if (ack) state <= MUL_IDLE;
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

  assign busy    = (state == MUL_RUN);
  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, sequential multiplier,
// and the EX/MEM pipeline register.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   ex_mem_en                      - EX/MEM load enable (0 = hold everything)
//   inst, read1, read2, imm_data   - ID/EX instruction and operands
//   forward_{ex,mem,wb}_data       - forwarded values
//   alu_src_sel1/2                 - operand forwarding selects
//   alu_src2_sel_rf_imm            - operand B takes imm_data
//   alu_cmd, write_addr, wr_en, mem_store_in, is_mem_cmd_in,
//   wb_mem_select_in               - control from ID/EX
//   ex_busy                        - multiply in flight; front end must hold
//   *_out                          - EX/MEM register outputs
// Handshake: a MUL with wr_en=1 seen in IDLE is accepted on that edge; ex_busy
// stays high until the product is ready, and the product enters EX/MEM on the
// first edge in DONE with ex_mem_en = 1 (upstream advances on that edge too).
module ex_stage
  import pipe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_mem_en,
  input  logic [15:0]   inst,
  input  logic [DW-1:0] read1,
  input  logic [DW-1:0] read2,
  input  logic [DW-1:0] imm_data,
  input  logic [DW-1:0] forward_ex_data,
  input  logic [DW-1:0] forward_mem_data,
  input  logic [DW-1:0] forward_wb_data,
  input  logic [1:0]    alu_src_sel1,
  input  logic [1:0]    alu_src_sel2,
  input  logic          alu_src2_sel_rf_imm,
  input  logic [2:0]    alu_cmd,
  input  logic [2:0]    write_addr,
  input  logic          wr_en,
  input  logic          mem_store_in,
  input  logic          is_mem_cmd_in,
  input  logic          wb_mem_select_in,
  output logic          ex_busy,
  output logic [15:0]   inst_out,
  output logic [DW-1:0] alu_result_out,
  output logic [DW-1:0] store_data_out,
  output logic [2:0]    write_addr_out,
  output logic          wr_en_out,
  output logic          mem_store_out,
  output logic          is_mem_cmd_out,
  output logic          wb_mem_select_out
);

  function automatic logic [DW-1:0] fwd_mux(input logic [1:0] sel,
                                            input logic [DW-1:0] rf,
                                            input logic [DW-1:0] ex,
                                            input logic [DW-1:0] mem,
                                            input logic [DW-1:0] wb);
    case (sel)
      FWD_EX:  return ex;
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return rf;
    endcase
  endfunction

  logic [DW-1:0] op_a, fwd_b, op_b, alu_res;

  assign op_a  = fwd_mux(alu_src_sel1, read1, forward_ex_data, forward_mem_data, forward_wb_data);
  assign fwd_b = fwd_mux(alu_src_sel2, read2, forward_ex_data, forward_mem_data, forward_wb_data);
  assign op_b  = alu_src2_sel_rf_imm ? imm_data : fwd_b;

  // MUL is handled by the sequential unit; a MUL bubble produces 0 here.
  always_comb begin
    alu_res = '0;
    case (alu_cmd)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SHL: alu_res = op_a << op_b[3:0];
      default: alu_res = '0;
    endcase
  end

  mul_state_t    mul_state;
  logic          mul_busy, mul_done, mul_start, mul_req;
  logic [DW-1:0] mul_product;

  // Only IDLE may start a multiply: a MUL still on the inputs during DONE
  // is the one being completed, not a new request.
  assign mul_req   = (alu_cmd == ALU_MUL) && wr_en;
  assign mul_start = mul_req && (mul_state == MUL_IDLE);
  assign ex_busy   = mul_start || mul_busy;

  seq_mul16 u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .ack     (ex_mem_en),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product),
    .state   (mul_state)
  );

  // Control for the multiply in flight, replayed into EX/MEM with the product.
  logic [15:0]   lat_inst;
  logic [DW-1:0] lat_store;
  logic [2:0]    lat_waddr;
  logic          lat_wr_en, lat_mstore, lat_ismem, lat_wbsel;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_inst   <= '0;
      lat_store  <= '0;
      lat_waddr  <= '0;
      lat_wr_en  <= 1'b0;
      lat_mstore <= 1'b0;
      lat_ismem  <= 1'b0;
      lat_wbsel  <= 1'b0;
    end else if (mul_start) begin
      lat_inst   <= inst;
      lat_store  <= fwd_b;
      lat_waddr  <= write_addr;
      lat_wr_en  <= wr_en;
      lat_mstore <= mem_store_in;
      lat_ismem  <= is_mem_cmd_in;
      lat_wbsel  <= wb_mem_select_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_out          <= '0;
      alu_result_out    <= '0;
      store_data_out    <= '0;
      write_addr_out    <= '0;
      wr_en_out         <= 1'b0;
      mem_store_out     <= 1'b0;
      is_mem_cmd_out    <= 1'b0;
      wb_mem_select_out <= 1'b0;
    end else if (ex_mem_en) begin
      if (mul_done) begin
        inst_out          <= lat_inst;
        alu_result_out    <= mul_product;
        store_data_out    <= lat_store;
        write_addr_out    <= lat_waddr;
        wr_en_out         <= lat_wr_en;
        mem_store_out     <= lat_mstore;
        is_mem_cmd_out    <= lat_ismem;
        wb_mem_select_out <= lat_wbsel;
      end else if (ex_busy) begin
        // Multiply accepted or iterating: downstream sees bubbles.
        inst_out          <= '0;
        alu_result_out    <= '0;
        store_data_out    <= '0;
        write_addr_out    <= '0;
        wr_en_out         <= 1'b0;
        mem_store_out     <= 1'b0;
        is_mem_cmd_out    <= 1'b0;
        wb_mem_select_out <= 1'b0;
      end else begin
        inst_out          <= inst;
        alu_result_out    <= alu_res;
        store_data_out    <= fwd_b;
        write_addr_out    <= write_addr;
        wr_en_out         <= wr_en;
        mem_store_out     <= mem_store_in;
        is_mem_cmd_out    <= is_mem_cmd_in;
        wb_mem_select_out <= wb_mem_select_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of single-cycle ALU vectors plus
// hand-written multiply, stall-in-DONE and mid-multiply reset sequences.
module tb_ex_stage;
  import pipe_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ex_mem_en;
  logic [15:0] inst, read1, read2, imm_data;
  logic [15:0] forward_ex_data, forward_mem_data, forward_wb_data;
  logic [1:0]  alu_src_sel1, alu_src_sel2;
  logic        alu_src2_sel_rf_imm;
  logic [2:0]  alu_cmd, write_addr;
  logic        wr_en, mem_store_in, is_mem_cmd_in, wb_mem_select_in;
  logic        ex_busy;
  logic [15:0] inst_out, alu_result_out, store_data_out;
  logic [2:0]  write_addr_out;
  logic        wr_en_out, mem_store_out, is_mem_cmd_out, wb_mem_select_out;

  ex_stage dut (
    .clk(clk), .rst(rst), .ex_mem_en(ex_mem_en), .inst(inst),
    .read1(read1), .read2(read2), .imm_data(imm_data),
    .forward_ex_data(forward_ex_data), .forward_mem_data(forward_mem_data),
    .forward_wb_data(forward_wb_data),
    .alu_src_sel1(alu_src_sel1), .alu_src_sel2(alu_src_sel2),
    .alu_src2_sel_rf_imm(alu_src2_sel_rf_imm), .alu_cmd(alu_cmd),
    .write_addr(write_addr), .wr_en(wr_en), .mem_store_in(mem_store_in),
    .is_mem_cmd_in(is_mem_cmd_in), .wb_mem_select_in(wb_mem_select_in),
    .ex_busy(ex_busy), .inst_out(inst_out), .alu_result_out(alu_result_out),
    .store_data_out(store_data_out), .write_addr_out(write_addr_out),
    .wr_en_out(wr_en_out), .mem_store_out(mem_store_out),
    .is_mem_cmd_out(is_mem_cmd_out), .wb_mem_select_out(wb_mem_select_out)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Pops the next expected ALU result and compares it.
  task automatic chk_result(input string name);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: expected queue empty", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, alu_result_out, e);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " inst_out"},   inst_out, 16'h0);
    chk({tag, " alu_result"}, alu_result_out, 16'h0);
    chk({tag, " store_data"}, store_data_out, 16'h0);
    chk({tag, " write_addr"}, {13'b0, write_addr_out}, 16'h0);
    chk({tag, " ctrl"}, {12'b0, wr_en_out, mem_store_out, is_mem_cmd_out, wb_mem_select_out}, 16'h0);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst = '0; read1 = '0; read2 = '0; imm_data = '0;
    forward_ex_data = '0; forward_mem_data = '0; forward_wb_data = '0;
    alu_src_sel1 = FWD_RF; alu_src_sel2 = FWD_RF; alu_src2_sel_rf_imm = 1'b0;
    alu_cmd = ALU_ADD; write_addr = '0; wr_en = 1'b0;
    mem_store_in = 1'b0; is_mem_cmd_in = 1'b0; wb_mem_select_in = 1'b0;
  endtask

  task automatic drive_rf(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] waddr, input logic we);
    clear_inputs();
    alu_cmd = cmd; read1 = a; read2 = b; write_addr = waddr; wr_en = we;
    inst = {4'hA, 1'b0, waddr, 5'b0, cmd};
  endtask

  typedef struct {
    logic [2:0]  cmd;
    logic [1:0]  s1, s2;
    logic        imm_sel;
    logic [15:0] r1, r2, imm, fex, fmem, fwb, inst;
    logic [2:0]  waddr;
    logic        ms, im, wb;
    logic [15:0] exp_res, exp_store;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          cmd      s1 s2 imm r1        r2        imm       fex       fmem      fwb       inst      wa  ms im wb  exp_res   exp_store
    vecs[0] = '{ALU_ADD, 2'd0, 2'd0, 1'b0, 16'd5,    16'd7,    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1001, 3'd1, 1'b0, 1'b0, 1'b0, 16'd12,   16'd7};
    vecs[1] = '{ALU_SUB, 2'd2, 2'd0, 1'b1, 16'h1111, 16'h2222, 16'hFFFF, 16'h0000, 16'h0100, 16'h0000, 16'h2002, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0101, 16'h2222};
    vecs[2] = '{ALU_AND, 2'd0, 2'd0, 1'b0, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3003, 3'd3, 1'b1, 1'b1, 1'b0, 16'h3030, 16'h3C3C};
    vecs[3] = '{ALU_OR,  2'd1, 2'd3, 1'b0, 16'hAAAA, 16'h5555, 16'h0000, 16'h1200, 16'h0000, 16'h0034, 16'h4004, 3'd4, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0034};
    vecs[4] = '{ALU_XOR, 2'd0, 2'd2, 1'b0, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 16'h5005, 3'd5, 1'b0, 1'b1, 1'b1, 16'hFF00, 16'h00FF};
    vecs[5] = '{ALU_SLT, 2'd0, 2'd0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h6006, 3'd6, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001};
    vecs[6] = '{ALU_SLT, 2'd0, 2'd0, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h6107, 3'd7, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF};
    vecs[7] = '{ALU_SHL, 2'd0, 2'd0, 1'b1, 16'h0001, 16'h7777, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 16'h7008, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0008, 16'h7777};
    vecs[8] = '{ALU_SHL, 2'd0, 2'd0, 1'b0, 16'h8001, 16'h000F, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7109, 3'd2, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h000F};
    vecs[9] = '{ALU_ADD, 2'd3, 2'd1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'hFFFF, 16'h100A, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0002};

    // ---- reset ----
    clear_inputs();
    ex_mem_en = 1'b1;
    rst = 1'b1;
    next_cycle(); next_cycle();
    rst = 1'b0;
    #2;
    chk_zero_outputs("reset");
    chk("reset ex_busy", {15'b0, ex_busy}, 16'h0);

    // ---- single-cycle vectors ----
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      alu_cmd = vecs[i].cmd; alu_src_sel1 = vecs[i].s1; alu_src_sel2 = vecs[i].s2;
      alu_src2_sel_rf_imm = vecs[i].imm_sel;
      read1 = vecs[i].r1; read2 = vecs[i].r2; imm_data = vecs[i].imm;
      forward_ex_data = vecs[i].fex; forward_mem_data = vecs[i].fmem;
      forward_wb_data = vecs[i].fwb; inst = vecs[i].inst;
      write_addr = vecs[i].waddr; wr_en = 1'b1;
      mem_store_in = vecs[i].ms; is_mem_cmd_in = vecs[i].im; wb_mem_select_in = vecs[i].wb;
      exp_q.push_back(vecs[i].exp_res);
      #1;
      chk($sformatf("vec%0d ex_busy", i), {15'b0, ex_busy}, 16'h0);
      next_cycle();
      #2;
      chk_result($sformatf("vec%0d alu_result", i));
      chk($sformatf("vec%0d store_data", i), store_data_out, vecs[i].exp_store);
      chk($sformatf("vec%0d inst_out", i), inst_out, vecs[i].inst);
      chk($sformatf("vec%0d write_addr", i), {13'b0, write_addr_out}, {13'b0, vecs[i].waddr});
      chk($sformatf("vec%0d ctrl", i),
          {12'b0, wr_en_out, mem_store_out, is_mem_cmd_out, wb_mem_select_out},
          {12'b0, 1'b1, vecs[i].ms, vecs[i].im, vecs[i].wb});
    end

    // ---- ex_mem_en = 0 in IDLE holds the last result (vec9: 0x0001) ----
    drive_rf(ALU_XOR, 16'h00F0, 16'h0F00, 3'd5, 1'b1);
    ex_mem_en = 1'b0;
    next_cycle(); #2;
    chk("idle hold alu_result", alu_result_out, 16'h0001);
    chk("idle hold write_addr", {13'b0, write_addr_out}, 16'd3);
    ex_mem_en = 1'b1;
    exp_q.push_back(16'h0FF0);
    next_cycle(); #2;
    chk_result("idle release alu_result");

    // ---- MUL 300 * 300: busy T..T+16, result at T+18 ----
    drive_rf(ALU_MUL, 16'd300, 16'd300, 3'd6, 1'b1);
    mem_store_in = 1'b0; is_mem_cmd_in = 1'b0; wb_mem_select_in = 1'b1;
    #1;
    chk("mul T ex_busy", {15'b0, ex_busy}, 16'h1);
    for (int k = 1; k <= 16; k++) begin
      next_cycle(); #2;
      chk($sformatf("mul T+%0d ex_busy", k), {15'b0, ex_busy}, 16'h1);
      chk($sformatf("mul T+%0d bubble", k),
          {alu_result_out[11:0], wr_en_out, mem_store_out, is_mem_cmd_out, wb_mem_select_out}, 16'h0);
    end
    next_cycle(); #2;   // T+17: DONE, MUL still on inputs
    chk("mul T+17 ex_busy", {15'b0, ex_busy}, 16'h0);
    chk("mul T+17 wr_en_out", {15'b0, wr_en_out}, 16'h0);
    next_cycle();       // T+18: upstream advances to a bubble
    clear_inputs();
    exp_q.push_back(16'h5F90);
    #2;
    chk_result("mul T+18 alu_result");
    chk("mul T+18 store_data", store_data_out, 16'd300);
    chk("mul T+18 write_addr", {13'b0, write_addr_out}, 16'd6);
    chk("mul T+18 ctrl", {12'b0, wr_en_out, mem_store_out, is_mem_cmd_out, wb_mem_select_out}, 16'h0009);
    chk("mul T+18 ex_busy", {15'b0, ex_busy}, 16'h0);
    next_cycle(); #2;
    chk("mul T+19 wr_en_out", {15'b0, wr_en_out}, 16'h0);
    chk("mul T+19 ex_busy", {15'b0, ex_busy}, 16'h0);

    // ---- MUL with wr_en = 0 is a bubble ----
    drive_rf(ALU_MUL, 16'd9, 16'd9, 3'd2, 1'b0);
    #1;
    chk("mul bubble ex_busy", {15'b0, ex_busy}, 16'h0);
    next_cycle(); #2;
    chk("mul bubble wr_en_out", {15'b0, wr_en_out}, 16'h0);
    chk("mul bubble ex_busy next", {15'b0, ex_busy}, 16'h0);

    // ---- MUL 3 * 5 with a 3-cycle stall in DONE ----
    drive_rf(ALU_MUL, 16'd3, 16'd5, 3'd4, 1'b1);
    for (int k = 1; k <= 17; k++) next_cycle();   // now in T+17 (DONE)
    ex_mem_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("done stall %0d ex_busy", k), {15'b0, ex_busy}, 16'h0);
      chk($sformatf("done stall %0d held", k), {alu_result_out[11:0], wr_en_out, 3'b0}, 16'h0);
      next_cycle();
    end
    #2;
    chk("done stall held final", alu_result_out, 16'h0);
    ex_mem_en = 1'b1;
    next_cycle();
    clear_inputs();
    exp_q.push_back(16'd15);
    #2;
    chk_result("done stall product");
    chk("done stall write_addr", {13'b0, write_addr_out}, 16'd4);
    chk("done stall wr_en_out", {15'b0, wr_en_out}, 16'h1);
    next_cycle(); #2;
    chk("done stall no restart", {15'b0, ex_busy}, 16'h0);

    // ---- reset at RUN count = 8 ----
    drive_rf(ALU_MUL, 16'd7, 16'd7, 3'd1, 1'b1);
    for (int k = 1; k <= 9; k++) next_cycle();    // T+9: count = 8
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive_rf(ALU_ADD, 16'd1, 16'd1, 3'd7, 1'b1);
    #2;
    chk_zero_outputs("mid-mul reset");
    chk("mid-mul reset ex_busy", {15'b0, ex_busy}, 16'h0);
    exp_q.push_back(16'd2);
    next_cycle(); #2;
    chk_result("post-reset add");
    chk("post-reset wr_en_out", {15'b0, wr_en_out}, 16'h1);

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover expected: got %0d entries expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit MIPS pipeline. Consumes the ID/EX register outputs (operands, immediate, forwarded data, control) and performs operand selection and the ALU operation.
- Contains an iterative 16-cycle shift-add multiplier for the MUL command.
- Drives the EX/MEM pipeline register, plus a stall output that freezes the front end while a multiply is in progress.

Parameters:
- DW, 16, datapath width.
- MUL_CYCLES, 16, multiplier iterations; equals DW.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_mem_en  in  1  EX/MEM register enable; 0 = downstream stall, hold all outputs
- inst  in  16  instruction from ID/EX
- read1, read2  in  16 each  register-file operands
- imm_data  in  16  sign-extended immediate
- forward_ex_data, forward_mem_data, forward_wb_data  in  16 each  forwarded values
- alu_src_sel1, alu_src_sel2  in  2 each  forwarding select: 0 = readN, 1 = ex, 2 = mem, 3 = wb
- alu_src2_sel_rf_imm  in  1  1 = operand B is imm_data
- alu_cmd  in  3  operation code
- write_addr  in  3  destination register
- wr_en, mem_store_in, is_mem_cmd_in, wb_mem_select_in  in  1 each  control
- ex_busy  out  1  multiply in progress; upstream must hold id_ex_en = 0 while high
- inst_out  out  16  registered inst
- alu_result_out  out  16  registered result / memory address
- store_data_out  out  16  registered forwarded operand B (before the imm mux)
- write_addr_out  out  3  registered write_addr
- wr_en_out, mem_store_out, is_mem_cmd_out, wb_mem_select_out  out  1 each  registered control

Behaviour:
- Operand selection:
  - opA = mux(alu_src_sel1: read1 / forward_ex_data / forward_mem_data / forward_wb_data).
  - fwdB = the same mux on alu_src_sel2 with read2.
  - opB = alu_src2_sel_rf_imm ? imm_data : fwdB.
- alu_cmd encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed; result 1/0), 6 SHL (opA << opB[3:0]), 7 MUL (low 16 bits of opA*opB).
- All arithmetic is modulo 2^16. No overflow flag.
- FSM states:
  - IDLE: mul_req = (alu_cmd == 7 && wr_en).
    - If mul_req: latch opA/opB and all control inputs, clear the 5-bit count, go to RUN.
    - Else: a single-cycle op, captured into EX/MEM when ex_mem_en = 1. Latency 1.
    - Bubbles (wr_en = 0) never start the multiplier.
  - RUN: one shift-add iteration per cycle; count increments. At count == MUL_CYCLES-1, go to DONE.
  - DONE: present the product with latched control. When ex_mem_en = 1, capture into EX/MEM and go to IDLE. Otherwise stay in DONE.
- ex_busy is combinational: 1 when (IDLE && mul_req) or RUN; 0 in DONE.
- In DONE, upstream advances on the same edge that EX/MEM captures. A MUL still visible on the inputs in DONE must not restart the multiplier.
- MUL presented in cycle T: result is visible at alu_result_out in cycle T+18 (ex_mem_en held 1).
- While in IDLE-with-mul_req or RUN, EX/MEM loads a bubble when ex_mem_en = 1:
  - all control outputs 0;
  - inst_out, alu_result_out, store_data_out, write_addr_out are 0.
- ex_mem_en = 0 in any state: EX/MEM outputs hold. The FSM continues RUN iterations but holds in DONE.
- Reset (including mid-multiply): FSM to IDLE, count 0, all outputs 0, ex_busy 0. The partial product is discarded.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU_ADD..ALU_MUL command localparams;
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB select codes;
  - DW.
- One sub-module, seq_mul16: start, operands, busy, done, product.
- Operand muxes and ALU stay inline in ex_stage.

Test Plan:
- ADD: read1 = 5, read2 = 7, sel = 0, imm_sel = 0, wr_en = 1 -> next cycle alu_result_out = 12, wr_en_out = 1, ex_busy never high.
- Forwarding: alu_src_sel1 = 2, forward_mem_data = 0x0100, imm_sel = 1, imm = 0xFFFF, SUB -> alu_result_out = 0x0101. store_data_out equals the selected fwdB.
- MUL: opA = 300, opB = 300 at cycle T -> ex_busy high T..T+16, bubbles on EX/MEM, alu_result_out = 0x5F90 (90000 mod 65536 = 24464) at T+18, no restart at T+17.
- MUL with wr_en = 0 (bubble) -> no busy, zero control out next cycle.
- ex_mem_en = 0 during DONE for 3 cycles -> outputs held, FSM stays in DONE; the product is captured on the first ex_mem_en = 1.
- rst asserted at RUN count = 8 -> next cycle all outputs 0, ex_busy 0. A following ADD 1+1 gives 2 one cycle later.
